// File: rtl/parity_pipe_gen_chk.sv
// Pipelined per-lane parity generator/checker with sticky error count and first-error tag.
// Optional PARITY_PIPE_INJECT_EN adds inj_lanes for forced bad-parity generation and check.

module parity_pipe_lane #(
    parameter int   LANE_W = 8,
    parameter logic SENSE  = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ld1,
    input  logic              ld2,
    input  logic              mode1,
    input  logic [LANE_W-1:0] data,
    input  logic              par,
    input  logic              inj,
    output logic              par_out,
    output logic              err
);
    logic x1, p1, i1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x1 <= 1'b0;
            p1 <= 1'b0;
            i1 <= 1'b0;
        end else if (ld1) begin
            x1 <= ^data;
            p1 <= par;
            i1 <= inj;
        end
    end

    // Injection inverts generated parity, or corrupts the supplied parity before compare.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_out <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (ld2)
                par_out <= x1 ^ SENSE ^ (~mode1 & i1);
            err <= ld2 & mode1 & ((x1 ^ p1 ^ i1) != SENSE);
        end
    end
endmodule

module parity_pipe_gen_chk #(
    parameter  int DATA_W    = 32,
    parameter  int LANE_W    = 8,
    parameter  int ODD_SENSE = 1,
    parameter  int TAG_W     = 22,
    parameter  int ERRCNT_W  = 8,
    localparam int LANES     = DATA_W / LANE_W
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    input  logic                mode,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [LANES-1:0]    par_in,
    input  logic [TAG_W-1:0]    tag_in,
    input  logic                clr_err,
`ifdef PARITY_PIPE_INJECT_EN
    input  logic [LANES-1:0]    inj_lanes,
`endif
    output logic                out_valid,
    output logic [LANES-1:0]    par_out,
    output logic [LANES-1:0]    err_lanes,
    output logic                par_err,
    output logic                sticky_err,
    output logic [ERRCNT_W-1:0] err_count,
    output logic [TAG_W-1:0]    err_tag
);
    localparam logic SENSE = (ODD_SENSE != 0);

    generate
        if (DATA_W % LANE_W != 0) begin : g_bad_width
            $error("parity_pipe_gen_chk: DATA_W must be a multiple of LANE_W");
        end
    endgenerate

    logic [LANES-1:0] inj;
`ifdef PARITY_PIPE_INJECT_EN
    assign inj = inj_lanes;
`else
    assign inj = '0;
`endif

    logic [2:1]       vld_pipe;
    logic             mode1;
    logic [TAG_W-1:0] tag1, tag2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            mode1    <= 1'b0;
            tag1     <= '0;
            tag2     <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1], in_valid};
            if (in_valid) begin
                mode1 <= mode;
                tag1  <= tag_in;
            end
            if (vld_pipe[1])
                tag2 <= tag1;
        end
    end

    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            parity_pipe_lane #(.LANE_W(LANE_W), .SENSE(SENSE)) u_lane (
                .clk     (clk),
                .reset_n (reset_n),
                .ld1     (in_valid),
                .ld2     (vld_pipe[1]),
                .mode1   (mode1),
                .data    (data_in[k*LANE_W +: LANE_W]),
                .par     (par_in[k]),
                .inj     (inj[k]),
                .par_out (par_out[k]),
                .err     (err_lanes[k])
            );
        end
    endgenerate

    assign out_valid = vld_pipe[2];
    assign par_err   = out_valid & (|err_lanes);

    // A clear on the same cycle as an error restarts the sticky state with that error.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky_err <= 1'b0;
            err_count  <= '0;
            err_tag    <= '0;
        end else if (clr_err) begin
            sticky_err <= par_err;
            err_count  <= ERRCNT_W'(par_err);
            err_tag    <= par_err ? tag2 : '0;
        end else if (par_err) begin
            sticky_err <= 1'b1;
            if (!(&err_count))
                err_count <= err_count + 1'b1;
            if (!sticky_err)
                err_tag <= tag2;
        end
    end
endmodule

// File: tb/tb_parity_pipe_gen_chk.sv
// Directed bench for parity_pipe_gen_chk: table of single transfers plus error/clear/reset sequences.

module tb_parity_pipe_gen_chk;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] data_in = '0;
    logic [3:0]  par_in = '0;
    logic [21:0] tag_in = '0;
    logic        clr_err = 1'b0;
`ifdef PARITY_PIPE_INJECT_EN
    logic [3:0]  inj_lanes = '0;
`endif
    logic        out_valid;
    logic [3:0]  par_out;
    logic [3:0]  err_lanes;
    logic        par_err;
    logic        sticky_err;
    logic [7:0]  err_count;
    logic [21:0] err_tag;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    parity_pipe_gen_chk dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .mode       (mode),
        .data_in    (data_in),
        .par_in     (par_in),
        .tag_in     (tag_in),
        .clr_err    (clr_err),
`ifdef PARITY_PIPE_INJECT_EN
        .inj_lanes  (inj_lanes),
`endif
        .out_valid  (out_valid),
        .par_out    (par_out),
        .err_lanes  (err_lanes),
        .par_err    (par_err),
        .sticky_err (sticky_err),
        .err_count  (err_count),
        .err_tag    (err_tag)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic m, input logic [31:0] d, input logic [3:0] p, input logic [21:0] t);
        in_valid = 1'b1;
        mode     = m;
        data_in  = d;
        par_in   = p;
        tag_in   = t;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        mode     = 1'b0;
        data_in  = '0;
        par_in   = '0;
        tag_in   = '0;
    endtask

    typedef struct {
        logic        mode;
        logic [31:0] data;
        logic [3:0]  par;
        logic [3:0]  exp_par;
        logic [3:0]  exp_err;
    } vec_t;

    vec_t tv[6];

    initial begin
        tv[0] = '{1'b0, 32'h000000FF, 4'b0000, 4'b1111, 4'b0000};
        tv[1] = '{1'b0, 32'h01010101, 4'b0000, 4'b0000, 4'b0000};
        tv[2] = '{1'b0, 32'hFFFFFFFF, 4'b0000, 4'b1111, 4'b0000};
        tv[3] = '{1'b0, 32'h80000001, 4'b0000, 4'b0110, 4'b0000};
        tv[4] = '{1'b1, 32'h12345678, 4'b1011, 4'b1011, 4'b0000};
        tv[5] = '{1'b0, 32'h12345678, 4'b0100, 4'b1011, 4'b0000};

        repeat (2) @(negedge clk);
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst par_out", 32'(par_out), 0);
        chk("rst err_lanes", 32'(err_lanes), 0);
        chk("rst par_err", 32'(par_err), 0);
        chk("rst sticky", 32'(sticky_err), 0);
        chk("rst count", 32'(err_count), 0);
        chk("rst tag", 32'(err_tag), 0);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk); drive(tv[i].mode, tv[i].data, tv[i].par, 22'(i));
            @(negedge clk); idle();
            chk($sformatf("v%0d early valid", i), 32'(out_valid), 0);
            @(negedge clk);
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 1);
            chk($sformatf("v%0d par_out", i), 32'(par_out), 32'(tv[i].exp_par));
            chk($sformatf("v%0d err_lanes", i), 32'(err_lanes), 32'(tv[i].exp_err));
            chk($sformatf("v%0d par_err", i), 32'(par_err), 0);
            @(negedge clk);
            chk($sformatf("v%0d idle valid", i), 32'(out_valid), 0);
            chk($sformatf("v%0d par_out hold", i), 32'(par_out), 32'(tv[i].exp_par));
        end
        chk("table count", 32'(err_count), 0);
        chk("table sticky", 32'(sticky_err), 0);

        // First error: lane 2 parity flipped
        @(negedge clk); drive(1'b1, 32'h12345678, 4'b1111, 22'h2A);
        @(negedge clk); idle();
        @(negedge clk);
        chk("e1 par_err", 32'(par_err), 1);
        chk("e1 err_lanes", 32'(err_lanes), 32'h4);
        chk("e1 par_out", 32'(par_out), 32'hB);
        chk("e1 sticky before", 32'(sticky_err), 0);
        @(negedge clk);
        chk("e1 sticky", 32'(sticky_err), 1);
        chk("e1 count", 32'(err_count), 1);
        chk("e1 tag", 32'(err_tag), 32'h2A);
        chk("e1 par_err idle", 32'(par_err), 0);
        chk("e1 err_lanes idle", 32'(err_lanes), 0);

        // Second error keeps first tag
        @(negedge clk); drive(1'b1, 32'h0, 4'b0000, 22'h15);
        @(negedge clk); idle();
        @(negedge clk);
        chk("e2 err_lanes", 32'(err_lanes), 32'hF);
        @(negedge clk);
        chk("e2 count", 32'(err_count), 2);
        chk("e2 tag", 32'(err_tag), 32'h2A);

        // 300 back-to-back errors saturate the counter
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); drive(1'b1, 32'h0, 4'b0000, 22'(i + 100));
        end
        @(negedge clk); idle();
        chk("b2b mid count", 32'(err_count), 32'hFF);
        repeat (4) @(negedge clk);
        chk("sat count", 32'(err_count), 32'hFF);
        chk("sat tag", 32'(err_tag), 32'h2A);
        chk("sat sticky", 32'(sticky_err), 1);

        // Clear on the same cycle as a new error
        @(negedge clk); drive(1'b1, 32'h0, 4'b0001, 22'h07);
        @(negedge clk); idle();
        @(negedge clk);
        chk("clr+err par_err", 32'(par_err), 1);
        clr_err = 1'b1;
        @(negedge clk); clr_err = 1'b0;
        chk("clr+err count", 32'(err_count), 1);
        chk("clr+err sticky", 32'(sticky_err), 1);
        chk("clr+err tag", 32'(err_tag), 32'h07);

        // Clear alone
        @(negedge clk); clr_err = 1'b1;
        @(negedge clk); clr_err = 1'b0;
        chk("clr count", 32'(err_count), 0);
        chk("clr sticky", 32'(sticky_err), 0);
        chk("clr tag", 32'(err_tag), 0);

        // Reset mid-stream: t0 at output with an error, t1 still in flight
        @(negedge clk); drive(1'b1, 32'h0, 4'b0000, 22'h11);
        @(negedge clk); drive(1'b0, 32'h0, 4'b0000, 22'h12);
        @(negedge clk); idle();
        chk("pre-rst par_err", 32'(par_err), 1);
        reset_n = 1'b0;
        #1;
        chk("mid-rst out_valid", 32'(out_valid), 0);
        chk("mid-rst par_out", 32'(par_out), 0);
        chk("mid-rst err_lanes", 32'(err_lanes), 0);
        chk("mid-rst par_err", 32'(par_err), 0);
        @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("post-rst valid %0d", i), 32'(out_valid), 0);
        end
        chk("post-rst count", 32'(err_count), 0);
        chk("post-rst sticky", 32'(sticky_err), 0);

`ifdef PARITY_PIPE_INJECT_EN
        @(negedge clk); drive(1'b0, 32'h0, 4'b0000, 22'h1); inj_lanes = 4'b0001;
        @(negedge clk); idle(); inj_lanes = '0;
        @(negedge clk);
        chk("inj gen par_out", 32'(par_out), 32'hE);
        chk("inj gen err", 32'(err_lanes), 0);
        @(negedge clk); drive(1'b1, 32'h0, 4'b1111, 22'h2); inj_lanes = 4'b1000;
        @(negedge clk); idle(); inj_lanes = '0;
        @(negedge clk);
        chk("inj chk err_lanes", 32'(err_lanes), 32'h8);
        chk("inj chk par_out", 32'(par_out), 32'hF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
